// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: button debounce, IDLE/RUN/PAUSE/LAP FSM, min:sec extension and display mux.
// Lap snapshot support is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_controller #(
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic        clk_10000Hz,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_lap_clear,
  input  logic [13:0] small_sec,
  input  logic        wrap_in,
  output logic        count_enable,
  output logic        counter_clear,
  output logic [1:0]  state,
  output logic [5:0]  disp_minutes,
  output logic [5:0]  disp_seconds,
  output logic [13:0] disp_small,
  output logic        lap_valid,
  output logic        overflow
);

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

  localparam logic [11:0] CNT_LAST = 12'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is start/stop, bit 1 is lap/clear.
  logic [1:0]  raw, sync1, sync2, deb, deb_q, press;
  logic [11:0] db_cnt [2];

  assign raw = {btn_lap_clear, btn_start_stop};

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_q  <= '0;
      db_cnt <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, keeping the sync chain two stages deep.
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 12'd1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  state_t state_q, state_d;
  logic   start_go, lap_go, clear_go;
  logic   clear_q;

  // Start wins a tie; the lap press in the same cycle is dropped.
  assign start_go = press[0];
  assign lap_go   = press[1] & ~press[0];
  assign clear_go = (state_q == PAUSE) && lap_go;

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_go;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_go) state_d = RUN;
      RUN:   if (start_go) state_d = PAUSE;
             else if (lap_go && LAP_EN) state_d = LAP;
      LAP:   if (start_go) state_d = PAUSE;
      PAUSE: if (start_go) state_d = RUN;
             else if (lap_go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic show_lap;

  always_comb begin
    count_enable = (state_q == RUN) || (state_q == LAP);
    show_lap     = (state_q == LAP);
  end

  assign state         = state_q;
  assign counter_clear = clear_q;

  logic [5:0] minutes, seconds;
  logic       overflow_q;

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      minutes    <= '0;
      seconds    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_go) begin
      minutes    <= '0;
      seconds    <= '0;
      overflow_q <= 1'b0;
    end else if (wrap_in && count_enable) begin
      if (seconds == 6'd59) begin
        seconds <= '0;
        if (minutes == 6'd59) begin
          minutes    <= '0;
          overflow_q <= 1'b1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end
  end

  assign overflow = overflow_q;

  logic [5:0]  lap_min, lap_sec;
  logic [13:0] lap_small;
  logic        lap_valid_q;

`ifdef STOPWATCH_LAP_EN
  logic capture_go;
  assign capture_go = ((state_q == RUN) || (state_q == LAP)) && lap_go;

  // Captures the pre-increment time when wrap_in lands on the capture edge.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      lap_min     <= '0;
      lap_sec     <= '0;
      lap_small   <= '0;
      lap_valid_q <= 1'b0;
    end else if (clear_go) begin
      lap_valid_q <= 1'b0;
    end else if (capture_go) begin
      lap_min     <= minutes;
      lap_sec     <= seconds;
      lap_small   <= small_sec;
      lap_valid_q <= 1'b1;
    end
  end
`else
  assign lap_min     = '0;
  assign lap_sec     = '0;
  assign lap_small   = '0;
  assign lap_valid_q = 1'b0;
`endif

  assign lap_valid = lap_valid_q;

  always_comb begin
    if (show_lap) begin
      disp_minutes = lap_min;
      disp_seconds = lap_sec;
      disp_small   = lap_small;
    end else begin
      disp_minutes = minutes;
      disp_seconds = seconds;
      disp_small   = small_sec;
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed self-checking bench for stopwatch_controller with DEBOUNCE_CYCLES=4.
// Lap checks follow whichever STOPWATCH_LAP_EN build is compiled.
module tb_stopwatch_controller;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bs, bl, wrap;
  logic [13:0] ss;
  logic        ce, cc, lap_valid, overflow;
  logic [1:0]  st;
  logic [5:0]  dmin, dsec;
  logic [13:0] dsmall;

  int checks = 0;
  int errors = 0;

  stopwatch_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_10000Hz    (clk),
    .reset          (rst),
    .btn_start_stop (bs),
    .btn_lap_clear  (bl),
    .small_sec      (ss),
    .wrap_in        (wrap),
    .count_enable   (ce),
    .counter_clear  (cc),
    .state          (st),
    .disp_minutes   (dmin),
    .disp_seconds   (dsec),
    .disp_small     (dsmall),
    .lap_valid      (lap_valid),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold long enough for the press to take effect, then release and let the release settle.
  task automatic press(input logic s, input logic l);
    bs = s;
    bl = l;
    tick(DB + 3);
    bs = 1'b0;
    bl = 1'b0;
    tick(DB + 4);
  endtask

  task automatic wraps(input int n);
    wrap = 1'b1;
    tick(n);
    wrap = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bs = 1'b0; bl = 1'b0; wrap = 1'b0; ss = '0;
    tick(2);
    check("rst_state", st, 0);
    check("rst_ce", ce, 0);
    check("rst_cc", cc, 0);
    check("rst_lap_valid", lap_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_disp", {dmin, dsec, dsmall}, 0);
    rst = 1'b0;

    // Press latency: state flips at edge k+6.
    bs = 1'b1;
    tick(6);
    check("latency_k5_state", st, 0);
    tick(1);
    check("latency_k6_state", st, 1);
    check("latency_k6_ce", ce, 1);
    bs = 1'b0;
    tick(DB + 4);

    press(1'b1, 1'b0);
    check("pause_state", st, 2);
    check("pause_ce", ce, 0);

    bs = 1'b1;
    tick(3);
    bs = 1'b0;
    tick(DB + 4);
    check("glitch_state", st, 2);

    press(1'b1, 1'b0);
    wraps(61);
    check("wrap61_min", dmin, 1);
    check("wrap61_sec", dsec, 1);

    press(1'b1, 1'b0);
    bl = 1'b1;
    tick(6);
    check("clr_pre_state", st, 2);
    check("clr_pre_cc", cc, 0);
    tick(1);
    check("clr_state", st, 0);
    check("clr_cc_high", cc, 1);
    check("clr_time", {dmin, dsec}, 0);
    tick(1);
    check("clr_cc_low", cc, 0);
    bl = 1'b0;
    tick(DB + 4);

    press(1'b1, 1'b0);
    wraps(3600);
    check("ovf_time", {dmin, dsec}, 0);
    check("ovf_flag", overflow, 1);

    wraps(5);
    ss = 14'd1234;
    press(1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
    check("lap_state", st, 3);
    check("lap_valid_set", lap_valid, 1);
    ss = 14'd2000;
    wraps(3);
    check("lap_frozen", {dmin, dsec, dsmall}, {6'd0, 6'd5, 14'd1234});
    press(1'b1, 1'b0);
    check("lap_pause_state", st, 2);
    check("lap_pause_live", {dmin, dsec, dsmall}, {6'd0, 6'd8, 14'd2000});
    check("lap_pause_valid", lap_valid, 1);
`else
    check("nolap_state", st, 1);
    check("nolap_valid", lap_valid, 0);
    check("nolap_live", {dmin, dsec, dsmall}, {6'd0, 6'd5, 14'd1234});
    ss = 14'd2000;
    wraps(3);
    check("nolap_sec", dsec, 8);
    press(1'b1, 1'b0);
    check("nolap_pause_state", st, 2);
`endif

    press(1'b0, 1'b1);
    check("clr2_state", st, 0);
    check("clr2_lap_valid", lap_valid, 0);
    check("clr2_overflow", overflow, 0);
    check("clr2_time", {dmin, dsec}, 0);
    ss = '0;

    press(1'b1, 1'b0);
    wraps(2);
    press(1'b1, 1'b1);
    check("tie_state", st, 2);
    check("tie_lap_valid", lap_valid, 0);
    wraps(2);
    check("paused_wrap_sec", dsec, 2);

    // Reset in RUN with a start press mid-debounce, button held through release.
    press(1'b1, 1'b0);
    wraps(3);
    bs = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", st, 0);
    check("async_rst_ce", ce, 0);
    check("async_rst_time", {dmin, dsec, dsmall}, 0);
    check("async_rst_flags", {cc, lap_valid, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(7);
    check("held_press_state", st, 1);
    bs = 1'b0;
    tick(DB + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
